// File: rtl/mem_access_ctrl.sv
// Purpose : RV32I memory-stage sequencer; runs loads, stores and sub-word read-modify-write on a single-port word memory.
// Latency : zero-wait memory: load/SW 2 cycles start-to-done, SB/SH 4 cycles; each bus wait adds one cycle.
// Backpress: stalls the pipeline while an access is in flight; the bus request is held until acked or timed out.
//
// Ports:
//   i_Clk_1, i_Rst_1          clock (rising edge), async active-high reset
//   i_Valid_1/i_Load_1/i_Store_1/i_LoadStoreWidth_2/i_ALUResult_32/i_MergedStoreData_32
//                             instruction from the memory stage (held stable while stalled)
//   o_LoadData_32             last word read from memory, held until the next read ack
//   o_Stall_1/o_Done_1/o_Misaligned_1/o_BusError_1
//                             pipeline status
//   o_MemReq_1/o_MemWe_1/o_MemAddr_32/o_MemWData_32/i_MemAck_1/i_MemRData_32
//                             memory bus; ack accepts the request and carries read data
module mem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        i_Clk_1,
    input  logic        i_Rst_1,
    input  logic        i_Valid_1,
    input  logic        i_Load_1,
    input  logic        i_Store_1,
    input  logic [1:0]  i_LoadStoreWidth_2,
    input  logic [31:0] i_ALUResult_32,
    input  logic [31:0] i_MergedStoreData_32,
    output logic [31:0] o_LoadData_32,
    output logic        o_Stall_1,
    output logic        o_Done_1,
    output logic        o_Misaligned_1,
    output logic        o_BusError_1,
    output logic        o_MemReq_1,
    output logic        o_MemWe_1,
    output logic [31:0] o_MemAddr_32,
    output logic [31:0] o_MemWData_32,
    input  logic        i_MemAck_1,
    input  logic [31:0] i_MemRData_32
);

    typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] waitCnt;
    logic             isRmw;      // SB/SH store: read, merge, then write
    logic             start;
    logic             misaligned;
    logic             ackSeen;
    logic             timeoutHit;

    // No new access is evaluated while reset is held, so every output reads 0 in reset.
    assign start      = i_Valid_1 & (i_Load_1 | i_Store_1) & ~i_Rst_1;
    assign misaligned = ((i_LoadStoreWidth_2 == 2'b01) & i_ALUResult_32[0])
                      | ((i_LoadStoreWidth_2 == 2'b10) & (i_ALUResult_32[1:0] != 2'b00));

    // An ack only counts while a request is actually outstanding.
    assign ackSeen    = i_MemAck_1 & o_MemReq_1;

    // The counter holds the number of unacked cycles already spent; the cycle that
    // would make it reach TIMEOUT ends the access instead.
    assign timeoutHit = (TIMEOUT != 0) && !ackSeen && (waitCnt == CNT_W'(TIMEOUT - 1));

    assign o_Misaligned_1 = (state == IDLE) & start & misaligned;
    assign o_Stall_1      = ((state == IDLE) & start & ~misaligned)
                          | (state == RD) | (state == MERGE) | (state == WR);

    always_ff @(posedge i_Clk_1 or posedge i_Rst_1) begin
        if (i_Rst_1) begin
            state         <= IDLE;
            waitCnt       <= '0;
            isRmw         <= 1'b0;
            o_LoadData_32 <= '0;
            o_Done_1      <= 1'b0;
            o_BusError_1  <= 1'b0;
            o_MemReq_1    <= 1'b0;
            o_MemWe_1     <= 1'b0;
            o_MemAddr_32  <= '0;
            o_MemWData_32 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !misaligned) begin
                        o_MemAddr_32 <= {i_ALUResult_32[31:2], 2'b00};
                        isRmw        <= i_Store_1 & (i_LoadStoreWidth_2 != 2'b10);
                        waitCnt      <= '0;
                        o_MemReq_1   <= 1'b1;
                        if (i_Store_1 && (i_LoadStoreWidth_2 == 2'b10)) begin
                            // Full-word store needs no read; the datapath word is final.
                            o_MemWData_32 <= i_MergedStoreData_32;
                            o_MemWe_1     <= 1'b1;
                            state         <= WR;
                        end else begin
                            o_MemWe_1 <= 1'b0;
                            state     <= RD;
                        end
                    end
                end
                RD: begin
                    if (ackSeen) begin
                        o_LoadData_32 <= i_MemRData_32;
                        o_MemReq_1    <= 1'b0;
                        if (isRmw) begin
                            state <= MERGE;
                        end else begin
                            o_Done_1 <= 1'b1;
                            state    <= DONE;
                        end
                    end else if (timeoutHit) begin
                        o_MemReq_1   <= 1'b0;
                        o_Done_1     <= 1'b1;
                        o_BusError_1 <= 1'b1;
                        state        <= DONE;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                MERGE: begin
                    // Datapath has merged the sub-word into the held read word by now.
                    o_MemWData_32 <= i_MergedStoreData_32;
                    o_MemReq_1    <= 1'b1;
                    o_MemWe_1     <= 1'b1;
                    waitCnt       <= '0;
                    state         <= WR;
                end
                WR: begin
                    if (ackSeen) begin
                        o_MemReq_1 <= 1'b0;
                        o_MemWe_1  <= 1'b0;
                        o_Done_1   <= 1'b1;
                        state      <= DONE;
                    end else if (timeoutHit) begin
                        o_MemReq_1   <= 1'b0;
                        o_MemWe_1    <= 1'b0;
                        o_Done_1     <= 1'b1;
                        o_BusError_1 <= 1'b1;
                        state        <= DONE;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    o_Done_1     <= 1'b0;
                    o_BusError_1 <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Purpose : directed check of mem_access_ctrl: table of single transactions plus multi-cycle corner sequences.
// Latency : n/a (testbench).
// Backpress: bench plays both pipeline and memory; memory acks immediately unless a sequence holds it off.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        load;
    logic        store;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] merged;
    logic [31:0] loadData;
    logic        stall;
    logic        done;
    logic        mis;
    logic        busErr;
    logic        req;
    logic        we;
    logic [31:0] memAddr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    int nCmp  = 0;
    int nFail = 0;

    mem_access_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .i_Clk_1              (clk),
        .i_Rst_1              (rst),
        .i_Valid_1            (valid),
        .i_Load_1             (load),
        .i_Store_1            (store),
        .i_LoadStoreWidth_2   (width),
        .i_ALUResult_32       (addr),
        .i_MergedStoreData_32 (merged),
        .o_LoadData_32        (loadData),
        .o_Stall_1            (stall),
        .o_Done_1             (done),
        .o_Misaligned_1       (mis),
        .o_BusError_1         (busErr),
        .o_MemReq_1           (req),
        .o_MemWe_1            (we),
        .o_MemAddr_32         (memAddr),
        .o_MemWData_32        (wdata),
        .i_MemAck_1           (ack),
        .i_MemRData_32        (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] merged;
        logic [31:0] rdata;
        logic        expMis;
        logic        expStall;
        int          expRd;
        int          expWr;
        logic [31:0] expAddr;
        logic [31:0] expWData;
        logic [31:0] expLoad;
        int          expLat;   // cycles start->DONE, -1 = never completes
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Applies one instruction in IDLE with a zero-wait memory and checks the whole transaction.
    task automatic runVec(input string tag, input vec_t v);
        int          lat;
        int          nRd;
        int          nWr;
        logic [31:0] seenAddr;
        logic [31:0] seenWData;
        logic        seenBusErr;
        lat = -1; nRd = 0; nWr = 0;
        seenAddr = '0; seenWData = '0; seenBusErr = 1'b0;
        valid = 1'b1; load = v.ld; store = v.st; width = v.width;
        addr = v.addr; merged = v.merged; ack = 1'b0;
        #1;
        chkb({tag, " misaligned"}, mis, v.expMis);
        chkb({tag, " stall@start"}, stall, v.expStall);
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            cyc();
            ack = 1'b0;
            if (done) begin
                lat = c;
                seenBusErr = busErr;
            end else if (req) begin
                if (we) begin
                    nWr++;
                    seenWData = wdata;
                end else begin
                    nRd++;
                    rdata = v.rdata;
                end
                seenAddr = memAddr;
                ack = 1'b1;
            end
        end
        chk({tag, " latency"}, lat, v.expLat);
        chk({tag, " reads"}, nRd, v.expRd);
        chk({tag, " writes"}, nWr, v.expWr);
        if (nRd + nWr > 0) chk({tag, " addr"}, seenAddr, v.expAddr);
        if (nWr > 0) chk({tag, " wdata"}, seenWData, v.expWData);
        if (lat >= 0) begin
            chkb({tag, " buserr"}, seenBusErr, 1'b0);
            chkb({tag, " stall@done"}, stall, 1'b0);
        end
        chk({tag, " loaddata"}, loadData, v.expLoad);
        valid = 1'b0; load = 1'b0; store = 1'b0; ack = 1'b0;
        cyc();
    endtask

    initial begin
        vec_t v;
        //          ld    st    w      addr           merged         rdata          mis   stall rd wr expAddr        expWData       expLoad        lat
        vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1, 1, 0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2};
        vecs[1]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0008, 32'h1234_5678, 32'h0,         1'b0, 1'b1, 0, 1, 32'h0000_0008, 32'h1234_5678, 32'hDEAD_BEEF, 2};
        vecs[2]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0101, 32'h0,         32'h0,         1'b1, 1'b0, 0, 0, 32'h0,         32'h0,         32'hDEAD_BEEF, -1};
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0102, 32'h0,         32'h0,         1'b1, 1'b0, 0, 0, 32'h0,         32'h0,         32'hDEAD_BEEF, -1};
        vecs[4]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0206, 32'hBEEF_3344, 32'h1122_3344, 1'b0, 1'b1, 1, 1, 32'h0000_0204, 32'hBEEF_3344, 32'h1122_3344, 4};
        vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0003, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b1, 1, 0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 2};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0102, 32'h0,         32'h0BAD_F00D, 1'b0, 1'b1, 1, 0, 32'h0000_0100, 32'h0,         32'h0BAD_F00D, 2};
        vecs[7]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0007, 32'h5555_5555, 32'h0,         1'b1, 1'b0, 0, 0, 32'h0,         32'h0,         32'h0BAD_F00D, -1};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0001, 32'h1111_5511, 32'h1111_1111, 1'b0, 1'b1, 1, 1, 32'h0000_0000, 32'h1111_5511, 32'h1111_1111, 4};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0055, 32'h0,         32'h0,         1'b0, 1'b0, 0, 0, 32'h0,         32'h0,         32'h1111_1111, -1};
        vecs[10] = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0,         32'h8000_0001, 1'b0, 1'b1, 1, 0, 32'hFFFF_FFFC, 32'h0,         32'h8000_0001, 2};
        vecs[11] = '{1'b1, 1'b0, 2'b01, 32'h0000_0103, 32'h0,         32'h0,         1'b1, 1'b0, 0, 0, 32'h0,         32'h0,         32'h8000_0001, -1};

        rst = 1'b1; valid = 1'b0; load = 1'b0; store = 1'b0; width = 2'b00;
        addr = '0; merged = '0; ack = 1'b0; rdata = '0;
        #12;
        chkb("reset req", req, 1'b0);
        chkb("reset stall", stall, 1'b0);
        chkb("reset done", done, 1'b0);
        chk("reset loaddata", loadData, 32'h0);
        chk("reset addr", memAddr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc();

        for (int i = 0; i < 12; i++) runVec($sformatf("v%0d", i), vecs[i]);

        // SB 0x203: read held off 3 cycles, ack during MERGE must be ignored.
        valid = 1'b1; load = 1'b0; store = 1'b1; width = 2'b00;
        addr = 32'h203; merged = 32'hAA22_3344;
        #1;
        chkb("sb stall@start", stall, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chkb($sformatf("sb rd%0d req", c), req, 1'b1);
            chkb($sformatf("sb rd%0d we", c), we, 1'b0);
            chk($sformatf("sb rd%0d addr", c), memAddr, 32'h200);
        end
        ack = 1'b1; rdata = 32'h1122_3344;
        cyc();
        chkb("sb merge req", req, 1'b0);
        chkb("sb merge stall", stall, 1'b1);
        chk("sb merge loaddata", loadData, 32'h1122_3344);
        cyc();
        ack = 1'b0;
        chkb("sb wr req", req, 1'b1);
        chkb("sb wr we", we, 1'b1);
        chk("sb wr addr", memAddr, 32'h200);
        chk("sb wr data", wdata, 32'hAA22_3344);
        ack = 1'b1;
        cyc();
        ack = 1'b0;
        chkb("sb done", done, 1'b1);
        chkb("sb buserr", busErr, 1'b0);
        chkb("sb stall@done", stall, 1'b0);
        valid = 1'b0; store = 1'b0;
        cyc();

        // LW with no ack: request held TIMEOUT cycles, then DONE with bus error.
        valid = 1'b1; load = 1'b1; width = 2'b10; addr = 32'h40;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chkb($sformatf("to req%0d", c), req, 1'b1);
            chk($sformatf("to addr%0d", c), memAddr, 32'h40);
        end
        cyc();
        chkb("to done", done, 1'b1);
        chkb("to buserr", busErr, 1'b1);
        chkb("to req dropped", req, 1'b0);
        chk("to loaddata kept", loadData, 32'h1122_3344);
        valid = 1'b0; load = 1'b0;
        cyc();
        chkb("to buserr cleared", busErr, 1'b0);
        v = '{1'b1, 1'b0, 2'b10, 32'h44, 32'h0, 32'h0F0F_0F0F, 1'b0, 1'b1, 1, 0, 32'h44, 32'h0, 32'h0F0F_0F0F, 2};
        runVec("to next lw", v);

        // SH 0x10, reset asserted while the write is outstanding.
        valid = 1'b1; store = 1'b1; width = 2'b01; addr = 32'h10; merged = 32'hAAAA_1234;
        cyc();
        chkb("rst rd req", req, 1'b1);
        ack = 1'b1; rdata = 32'hAAAA_5555;
        cyc();
        ack = 1'b0;
        cyc();
        chkb("rst wr req", req, 1'b1);
        chkb("rst wr we", we, 1'b1);
        chk("rst wr data", wdata, 32'hAAAA_1234);
        rst = 1'b1; valid = 1'b0; store = 1'b0;
        #1;
        chkb("rst req dropped", req, 1'b0);
        chkb("rst we", we, 1'b0);
        chk("rst addr", memAddr, 32'h0);
        chk("rst wdata", wdata, 32'h0);
        chk("rst loaddata", loadData, 32'h0);
        chkb("rst stall", stall, 1'b0);
        chkb("rst done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chkb("rst no write after release", req, 1'b0);
        v = '{1'b1, 1'b0, 2'b00, 32'h21, 32'h0, 32'h7766_5544, 1'b0, 1'b1, 1, 0, 32'h20, 32'h0, 32'h7766_5544, 2};
        runVec("rst lb", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer for the RV32I memory stage. It drives a single-port, word-addressed data memory through a req/ack handshake and stalls the pipeline while an access is in flight. It runs sub-word stores (SB/SH) as read-modify-write: it reads the word, returns it to the memory-stage datapath, captures the merged word that comes back, then writes it. It also flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, max cycles waiting for i_MemAck_1 in RD/WR before bus error; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
i_Clk_1  in  1  clock, rising edge.
i_Rst_1  in  1  reset, asynchronous, active-high.
i_Valid_1  in  1  memory stage holds a valid instruction.
i_Load_1  in  1  instruction is a load.
i_Store_1  in  1  instruction is a store.
i_LoadStoreWidth_2  in  2  00 byte, 01 half, 10 word.
i_ALUResult_32  in  32  byte address.
i_MergedStoreData_32  in  32  store word from the datapath (merged for SB/SH, raw for SW).
o_LoadData_32  out  32  registered memory read word, fed to the datapath load-data input.
o_Stall_1  out  1  freeze PC and the EX/MEM registers.
o_Done_1  out  1  one-cycle pulse when the access completes.
o_Misaligned_1  out  1  one-cycle pulse on a misaligned access.
o_BusError_1  out  1  high during DONE if the access timed out.
o_MemReq_1  out  1  memory request.
o_MemWe_1  out  1  1 = write, 0 = read.
o_MemAddr_32  out  32  word address, bits [1:0] always 00.
o_MemWData_32  out  32  write data.
i_MemAck_1  in  1  request accepted; read data valid in the same cycle.
i_MemRData_32  in  32  read data.

Behaviour:
- Reset (async, i_Rst_1=1): state IDLE. Every output register is 0, including o_LoadData_32 and the counter. o_MemReq_1 drops in the reset cycle, so a reset mid-access abandons the access with no write issued.
- States: IDLE, RD, MERGE, WR, DONE. Encoding is free.
- Start condition: start = i_Valid_1 & (i_Load_1 | i_Store_1), evaluated in IDLE only.
- Misaligned rule: half with addr[0]=1, or word with addr[1:0]!=00.
- IDLE, start and misaligned: o_Misaligned_1=1 for that cycle. No memory access. Stay in IDLE. No stall.
- IDLE, start and aligned:
  - Latch word address {addr[31:2],2'b00}, op and width.
  - Load, SB or SH -> RD.
  - SW: capture i_MergedStoreData_32 into the write-data register -> WR.
- RD: o_MemReq_1=1, o_MemWe_1=0. On ack:
  - o_LoadData_32 <= i_MemRData_32.
  - Load -> DONE.
  - SB/SH -> MERGE.
- MERGE: one cycle so the datapath can merge using the held o_LoadData_32. Capture i_MergedStoreData_32 into the write-data register -> WR.
- WR: o_MemReq_1=1, o_MemWe_1=1, o_MemWData_32 = write-data register. On ack -> DONE.
- Request hold rule: o_MemReq_1, o_MemAddr_32, o_MemWe_1 and o_MemWData_32 stay constant from req assertion until ack. An ack in the first req cycle is valid. An ack while req=0 is ignored.
- Timeout:
  - Counter clears on entry to RD or WR and increments each cycle without ack.
  - When it reaches TIMEOUT (TIMEOUT!=0), go to DONE with the error flag set. o_LoadData_32 is unchanged and no write is issued.
- DONE: o_Done_1=1, o_BusError_1 = error flag, o_Stall_1=0 -> IDLE. The error flag clears on leaving DONE.
- o_Stall_1 is combinational: (IDLE & start & aligned) | RD | MERGE | WR. It is 0 in DONE and for non-memory or misaligned instructions.
- Pipeline contract: the pipeline holds all i_* pipeline inputs stable while o_Stall_1=1.
- Back-to-back: a new instruction arrives the cycle after DONE and is evaluated in IDLE.
- o_LoadData_32 holds its value until the next RD ack.
- Minimum latency with zero-wait memory, counted from the IDLE start cycle to DONE:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.

Test Plan:
- LW addr 0x100, memory acks immediately with 0xDEADBEEF -> req/we=0/addr 0x100 in cycle 1, o_LoadData_32=0xDEADBEEF and o_Done_1 in cycle 2, o_Stall_1=1 in cycles 0-1 only.
- SB addr 0x203, old word 0x11223344, datapath merge returns 0xAA223344, ack delayed 3 cycles on the read -> read addr 0x200, then MERGE, then write we=1 data 0xAA223344; req/addr stable throughout each wait.
- SW addr 0x8 data 0x12345678 -> no read issued, single write 0x12345678 to 0x8, o_Done_1 two cycles after start.
- LH addr 0x101 and LW addr 0x102 -> o_Misaligned_1 pulse each, o_MemReq_1 stays 0, o_Stall_1 stays 0.
- TIMEOUT=4, LW with ack never asserted -> req held 4 cycles, then DONE with o_BusError_1=1, o_LoadData_32 unchanged; the next LW completes normally with o_BusError_1=0.
- Assert i_Rst_1 mid-WR of an SH -> o_MemReq_1 drops in the same cycle, state IDLE, all outputs 0; an LB issued after release completes normally.
